// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shifter: operation codes, FSM
// state encoding and a small helper used to pick the per-cycle step size.
package shift_pkg;

  // Shift operation selector as presented on the Op port.
  typedef logic [1:0] shift_op_t;

  localparam shift_op_t OP_SLL = 2'b00;  // logical left, zero fill at LSB
  localparam shift_op_t OP_SRL = 2'b01;  // logical right, zero fill at MSB
  localparam shift_op_t OP_SRA = 2'b10;  // arithmetic right, sign fill
  localparam shift_op_t OP_ROR = 2'b11;  // rotate right

  // Controller states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Number of clock edges from the capture edge until Done is presented:
  // one edge per STEP-sized chunk of the shift amount plus the final
  // SHIFT->DONE transition.
  function automatic int shift_latency(input int shamt, input int step);
    return ((shamt + step - 1) / step) + 1;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by k positions (k <= STEP)
// applying the fill rule of the selected operation.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int K_W   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [K_W-1:0]   k,
  input  shift_op_t        op,
  input  logic             sign,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] srl_val;
  logic [WIDTH-1:0] sign_mask;
  logic [WIDTH-1:0] rot_in;

  // Shared partial results: plain right shift, the MSB positions vacated
  // by it, and the LSB bits that wrap around for a rotate.
  always_comb begin
    srl_val   = data >> k;
    sign_mask = ~({WIDTH{1'b1}} >> k);
    // k == 0 gives a shift by WIDTH, which yields zero: no wrap-in.
    rot_in    = data << (WIDTH - int'(k));
  end

  // Apply the fill rule for the requested operation.
  always_comb begin
    shifted = data;
    case (op)
      OP_SLL: shifted = data << k;
      OP_SRL: shifted = srl_val;
      OP_SRA: shifted = sign ? (srl_val | sign_mask) : srl_val;
      OP_ROR: shifted = srl_val | rot_in;
      default: shifted = data;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle variable shifter (SLL/SRL/SRA/ROR) moving up to STEP bit
// positions per clock under a Start/Busy/Done handshake.
//
// Handshake: a request (Start=1 with Op/Operand/Shamt) is accepted on a
// rising edge when Busy=0 (state IDLE or DONE); request fields are only
// sampled on that edge. Busy stays high until the result is final; Done
// then pulses for exactly one cycle with Result valid, and Result holds
// until the next accepted request. Start while Busy=1 is dropped.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  shift_op_t          Op,
  input  logic [WIDTH-1:0]   Operand,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Result,
  output logic [1:0]         dbg_state
);

  localparam int K_W = $clog2(STEP) + 1;

  state_t             state;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] rem_q;
  shift_op_t          op_q;
  logic               sign_q;

  logic [K_W-1:0]     k;
  logic [WIDTH-1:0]   data_next;
  logic               accept;

  // A request is taken whenever the unit is not mid-shift.
  always_comb begin
    accept = Start && (state != ST_SHIFT);
  end

  // Per-cycle step size: min(STEP, rem).
  always_comb begin
    k = '0;
    if ({1'b0, rem_q} >= (SHAMT_W + 1)'(STEP)) begin
      k = K_W'(STEP);
    end else begin
      k = K_W'(rem_q);
    end
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .K_W   (K_W)
  ) u_step (
    .data    (data_next_src()),
    .k       (k),
    .op      (op_q),
    .sign    (sign_q),
    .shifted (data_next)
  );

  // The step shifter always works on the data register.
  function automatic logic [WIDTH-1:0] data_next_src();
    return data_q;
  endfunction

  // Controller FSM with the datapath registers and registered Busy/Done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      data_q <= '0;
      rem_q  <= '0;
      op_q   <= OP_SLL;
      sign_q <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else if (accept) begin
      // Capture a new request from IDLE, or back-to-back from DONE.
      state  <= ST_SHIFT;
      data_q <= Operand;
      rem_q  <= Shamt;
      op_q   <= Op;
      sign_q <= Operand[WIDTH-1];
      Busy   <= 1'b1;
      Done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Busy <= 1'b0;
          Done <= 1'b0;
        end
        ST_SHIFT: begin
          if (rem_q != '0) begin
            data_q <= data_next;
            rem_q  <= rem_q - SHAMT_W'(k);
          end else begin
            // Shift complete: no data movement on this edge.
            state <= ST_DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

  // Result is the data register itself; it holds outside of SHIFT.
  always_comb begin
    Result    = data_q;
    dbg_state = state;
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: four instances with STEP = 1, 2, 4, 8 share a
// reset; each is driven independently. A driver pushes expected results into
// a queue and a monitor pops and compares on every Done pulse.
module tb_seq_shift_unit;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]         start_v;
  logic [N-1:0][1:0]    op_v;
  logic [N-1:0][W-1:0]  operand_v;
  logic [N-1:0][SW-1:0] shamt_v;
  logic [N-1:0]         busy_v;
  logic [N-1:0]         done_v;
  logic [N-1:0][W-1:0]  result_v;
  logic [N-1:0][1:0]    state_v;

  logic [W-1:0] exp_q[$];
  int           idx_q[$];

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int dones = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    seq_shift_unit #(
      .WIDTH (W),
      .STEP  (1 << g)
    ) u_dut (
      .clk       (clk),
      .reset     (rst),
      .Start     (start_v[g]),
      .Op        (op_v[g]),
      .Operand   (operand_v[g]),
      .Shamt     (shamt_v[g]),
      .Busy      (busy_v[g]),
      .Done      (done_v[g]),
      .Result    (result_v[g]),
      .dbg_state (state_v[g])
    );
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: the shift rules in plain arithmetic.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] op, input logic [W-1:0] a, input int sh);
    logic [2*W-1:0] dbl;
    case (op)
      2'b00: return a << sh;
      2'b01: return a >> sh;
      2'b10: return W'($signed(a) >>> sh);
      default: begin
        dbl = {a, a} >> sh;
        return dbl[W-1:0];
      end
    endcase
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (done_v[i] === 1'b1) begin
        dones++;
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_done_inst%0d", i), 1, 0);
        end else begin
          check("done_instance", W'(i), W'(idx_q.pop_front()));
          check($sformatf("result_inst%0d", i), result_v[i], exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle(input int i);
    for (int n = 0; n < 200 && busy_v[i]; n++) begin
      @(posedge clk); #1;
    end
    if (busy_v[i]) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_done(input int i, output int edges, output int busy_cycles);
    bit got = 0;
    edges = 0;
    busy_cycles = busy_v[i] ? 1 : 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk); #1;
      edges++;
      if (done_v[i]) got = 1;
      else if (busy_v[i]) busy_cycles++;
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [W-1:0] a,
                       input int sh, input logic [W-1:0] exp);
    op_v[i] = op;
    operand_v[i] = a;
    shamt_v[i] = SW'(sh);
    start_v[i] = 1'b1;
    exp_q.push_back(exp);
    idx_q.push_back(i);
    accepts++;
  endtask

  // Full transaction with latency, busy-length and hold checks.
  task automatic run_op(input int i, input logic [1:0] op, input logic [W-1:0] a,
                        input int sh, input logic [W-1:0] exp);
    int edges, bcyc, lat;
    lat = ((sh + (1 << i) - 1) / (1 << i)) + 1;
    wait_idle(i);
    issue(i, op, a, sh, exp);
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    operand_v[i] = $urandom;
    op_v[i] = 2'($urandom_range(0, 3));
    shamt_v[i] = SW'($urandom_range(0, 31));
    wait_done(i, edges, bcyc);
    check("latency_edges", W'(edges), W'(lat));
    check("busy_cycles", W'(bcyc), W'(lat));
    @(posedge clk); #1;
    check("result_held", result_v[i], exp);
    check("done_one_cycle", W'(done_v[i]), 0);
  endtask

  initial begin
    int edges, bcyc;
    start_v = '0; op_v = '0; operand_v = '0; shamt_v = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check("reset_busy", W'(busy_v[i]), 0);
      check("reset_done", W'(done_v[i]), 0);
      check("reset_result", result_v[i], 0);
      check("reset_state", W'(state_v[i]), 0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_op(0, 2'b00, 32'h0000_0001, 2, 32'h0000_0004);
    run_op(0, 2'b10, 32'h8000_0000, 31, 32'hFFFF_FFFF);
    run_op(0, 2'b01, 32'h8000_0000, 31, 32'h0000_0001);
    run_op(2, 2'b11, 32'h0000_00F1, 4, 32'h1000_000F);
    run_op(2, 2'b11, 32'h0000_00F1, 0, 32'h0000_00F1);
    run_op(3, 2'b11, 32'h1234_5678, 31, 32'h2468_ACF0);
    run_op(1, 2'b10, 32'h7000_0000, 3, 32'h0E00_0000);

    // Back-to-back: new request accepted in the DONE cycle.
    wait_idle(0);
    issue(0, 2'b01, 32'hF000_0000, 3, 32'h1E00_0000);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, edges, bcyc);
    check("b2b_first_latency", W'(edges), 4);
    issue(0, 2'b00, 32'h0000_0003, 5, 32'h0000_0060);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("b2b_no_gap_busy", W'(busy_v[0]), 1);
    wait_done(0, edges, bcyc);
    check("b2b_second_latency", W'(edges), 6);

    // Start while busy is dropped.
    wait_idle(0);
    issue(0, 2'b11, 32'h1234_5678, 8, 32'h7812_3456);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    op_v[0] = 2'b00; operand_v[0] = 32'hFFFF_FFFF; shamt_v[0] = 5'd1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, edges, bcyc);
    repeat (12) @(posedge clk);
    #1;

    // Reset in the second SHIFT cycle abandons the operation.
    wait_idle(0);
    op_v[0] = 2'b00; operand_v[0] = 32'h0000_0ABC; shamt_v[0] = 5'd10;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_busy", W'(busy_v[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_busy", W'(busy_v[0]), 0);
    check("async_reset_done", W'(done_v[0]), 0);
    check("async_reset_result", result_v[0], 0);
    @(negedge clk) rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    run_op(0, 2'b00, 32'h0000_0ABC, 10, 32'h002A_F000);

    // Randomised sweep over Op x Shamt on STEP = 1, 2, 8.
    for (int r = 0; r < 90; r++) begin
      int i, sh;
      logic [1:0] op;
      logic [W-1:0] a;
      i = (r % 3 == 2) ? 3 : (r % 3);
      op = 2'($urandom_range(0, 3));
      sh = $urandom_range(0, 31);
      a = $urandom;
      run_op(i, op, a, sh, ref_shift(op, a, sh));
    end

    // Drain and account.
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    check("queue_drained", W'(exp_q.size()), 0);
    check("done_count", W'(dones), W'(accepts));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
